// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin, packet-locked arbiter feeding a one-entry output register.
// The owner keeps the channel until a beat with last=1 transfers; ties go to the
// requester that was not served most recently.
module mux2_rr_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_last,
  input  logic             y_ready,
  output logic             sel,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_cnt_a,
  output logic [CNT_W-1:0] pkt_cnt_b
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_served_q;   // 0 = A served last, 1 = B served last
  logic   load_ok_c;
  logic   a_xfer_c, b_xfer_c;
  logic   a_eop_c, b_eop_c;

  // Output register can accept a beat when empty or draining this cycle
  assign load_ok_c = !y_valid || y_ready;
  assign a_xfer_c  = a_valid && a_ready;
  assign b_xfer_c  = b_valid && b_ready;
  assign a_eop_c   = a_xfer_c && a_last;
  assign b_eop_c   = b_xfer_c && b_last;

  // Next-state arbitration and owner ready generation
  always_comb begin
    state_d = state_q;
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_valid && b_valid) state_d = last_served_q ? OWN_A : OWN_B;
        else if (a_valid)       state_d = OWN_A;
        else if (b_valid)       state_d = OWN_B;
      end
      OWN_A: begin
        a_ready = load_ok_c;
        if (a_valid && load_ok_c && a_last) state_d = IDLE;
      end
      OWN_B: begin
        b_ready = load_ok_c;
        if (b_valid && load_ok_c && b_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with owner bookkeeping (sel, busy, last_served)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      sel           <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      if (state_d == OWN_A)      sel <= 1'b0;
      else if (state_d == OWN_B) sel <= 1'b1;
      if (a_eop_c)      last_served_q <= 1'b0;
      else if (b_eop_c) last_served_q <= 1'b1;
    end
  end

  // One-entry output register: load from owner, clear on drain without reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid <= 1'b0;
      y_data  <= '0;
      y_last  <= 1'b0;
    end else if (a_xfer_c) begin
      y_valid <= 1'b1;
      y_data  <= a_data;
      y_last  <= a_last;
    end else if (b_xfer_c) begin
      y_valid <= 1'b1;
      y_data  <= b_data;
      y_last  <= b_last;
    end else if (y_valid && y_ready) begin
      y_valid <= 1'b0;
    end
  end

  // Completed-packet counters, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_a <= '0;
      pkt_cnt_b <= '0;
    end else begin
      if (a_eop_c) pkt_cnt_a <= pkt_cnt_a + CNT_W'(1);
      if (b_eop_c) pkt_cnt_b <= pkt_cnt_b + CNT_W'(1);
    end
  end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Shares one WIDTH-bit output channel between two requesters (A, B) using valid/ready handshakes.
- Grants are round-robin and packet-locked: the owner keeps the channel until it transfers a beat with last=1.
- Drives the select of the downstream 2:1 mux (sel=0 means A, sel=1 means B) and holds the output in a one-entry register.
- Sits between two producer blocks and a single consumer in the lab datapath.

Parameters:
WIDTH, 8, data width of each requester and of the output
CNT_W, 16, width of the per-requester completed-packet counters

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
a_valid  input  1  requester A has a beat
a_data  input  WIDTH  requester A beat data
a_last  input  1  final beat of A's packet
a_ready  output  1  A beat accepted this cycle when a_valid is also high
b_valid  input  1  requester B has a beat
b_data  input  WIDTH  requester B beat data
b_last  input  1  final beat of B's packet
b_ready  output  1  B beat accepted this cycle when b_valid is also high
y_valid  output  1  output register holds a beat
y_data  output  WIDTH  output beat data
y_last  output  1  output beat is the last of its packet
y_ready  input  1  consumer accepts the output beat
sel  output  1  current or most recent owner (0=A, 1=B)
busy  output  1  high while any owner holds the grant
pkt_cnt_a  output  CNT_W  packets completed by A
pkt_cnt_b  output  CNT_W  packets completed by B

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - While rst_n=0: state=IDLE, last_served=B (so A wins the first tie), sel=0, busy=0, y_valid=0, y_data=0, y_last=0, a_ready=0, b_ready=0, counters=0.
  - Asserting reset mid-packet discards the partial packet and the output register contents. The requester must restart its packet.
- FSM states: IDLE, OWN_A, OWN_B. All transitions occur on the rising clock edge.
- IDLE:
  - Only a_valid high -> OWN_A.
  - Only b_valid high -> OWN_B.
  - Both high -> the requester other than last_served.
  - Neither high -> stay in IDLE.
  - a_ready=b_ready=0. sel holds its previous value.
- Arbitration latency: a valid seen at edge k gives ownership after edge k. The owner's ready can be high in the cycle following edge k, so the first transfer lands at edge k+1 at the earliest.
- Output register control:
  - load_ok = !y_valid || y_ready.
  - a_ready = (state==OWN_A) && load_ok; b_ready = (state==OWN_B) && load_ok. The non-owner's ready is always 0.
- Beat transfer (owner valid && ready at an edge): y_data and y_last load the owner's data and last, and y_valid=1.
- Output handshake: y_valid && y_ready with no new load at the same edge -> y_valid=0.
  - If a load and a drain occur at the same edge, y_valid stays 1 with the new beat. Throughput is one beat per cycle.
- Output stability: while y_valid=1 and y_ready=0, y_data and y_last are held stable.
- End of packet: a transfer with last=1 makes, at that edge:
  - state -> IDLE;
  - last_served = owner;
  - the owner's pkt_cnt increments, wrapping from 2^CNT_W-1 to 0.
  This gives one idle arbitration cycle between packets.
- Ownership persistence: the owner keeps the grant while its valid is low mid-packet. There is no timeout and no preemption. The other requester waits.
- sel: 0 in OWN_A, 1 in OWN_B. It updates on entry to the state and holds its value in IDLE.
- busy = (state != IDLE).
- Requester data need only be stable while valid is high and ready is low.
- A one-beat packet (last=1 on the first beat) is legal and takes 2 cycles of ownership: the grant cycle and the transfer cycle.

Test Plan:
1. Reset with a_valid=1: hold rst_n=0 for 3 cycles -> y_valid=0, busy=0, sel=0, a_ready=0. After release, a_ready=1 on the 2nd cycle and a_data=8'h3C appears on y_data one cycle later.
2. Tie: a_valid=b_valid=1, each sending 2-beat packets, y_ready=1 -> grant order A, B, A, B. sel toggles 0,1,0,1. pkt_cnt_a=pkt_cnt_b=2 after four packets.
3. Backpressure: A sends 8'h11, 8'h22, 8'h33 (last on 8'h33) with y_ready=0 for 4 cycles -> y_data holds 8'h11 and a_ready=0. When y_ready returns to 1, the beats emerge in order with no loss or duplication, and y_last=1 only on 8'h33.
4. Lock: A drops a_valid mid-packet for 5 cycles while b_valid=1 -> b_ready stays 0 and busy=1. A's resumed beats complete the packet, then B is granted.
5. Reset mid-packet: assert rst_n=0 after A's 2nd beat -> y_valid drops to 0 immediately (asynchronous), state=IDLE, pkt_cnt_a=0. The next tie grants A.
6. Wrap: with CNT_W=2, send 5 one-beat packets from B -> pkt_cnt_b reads 1,2,3,0,1.
